// File: rtl/lsrx_frame_if.sv
// lsrx_frame_if
//   Host-facing bundle of the lsrx_frame receiver: the serial line, the
//   toggle-style pop/clear requests and the received word with its status.
//   master : the link/host side (drives rx, pop, clear; observes status)
//   slave  : the receiver (observes rx, pop, clear; drives status)
//   Parameter DMSB : MSB of the data word.
interface lsrx_frame_if #(
    parameter int DMSB = 9
);
    logic                   rx;     // serial line, idles high
    logic                   pop;    // toggle: each edge consumes rdata
    logic                   clear;  // toggle: each edge aborts and flushes
    logic signed [DMSB:0]   rdata;  // last accepted word
    logic                   full;   // rdata holds an unconsumed word
    logic                   ferr;   // sticky framing error
    logic                   perr;   // sticky parity error
    logic                   ovr;    // sticky overrun

    modport master (
        output rx, pop, clear,
        input  rdata, full, ferr, perr, ovr
    );

    modport slave (
        input  rx, pop, clear,
        output rdata, full, ferr, perr, ovr
    );
endinterface

// File: rtl/lsrx_frame.sv
// lsrx_frame
//   Framed, self-synchronising serial receiver. Hunts for a start bit on
//   bus.rx, samples each bit at mid-bit using the fclk tick stream and the
//   div half-bit divider, and presents accepted words on bus.rdata.
//   Frame: 1 start (0), DMSB+1 data bits LSB first, optional even parity,
//   1 stop (1).
// Ports
//   clk   : clock, all logic on posedge
//   rstn  : synchronous active-low reset
//   setn  : 0 freezes every register, synchronisers included
//   fclk  : tick toggle, each edge is one tick
//   div   : half-bit length minus 1 in ticks, captured at start detection
//   bus   : lsrx_frame_if.slave (rx, pop, clear in; rdata, full, ferr,
//           perr, ovr out)
//   cst   : current state, nst : next state
//   xst   : one-cycle pulse in the cycle cst takes a new value
// Build option
//   LSRX_FRAME_PARITY_EN : when defined, a parity bit follows the data bits
//   and perr is live; otherwise perr is tied 0 and no parity logic exists.
module lsrx_frame #(
    parameter int BMSB = 3,
    parameter int DMSB = 9,
    parameter int CMSB = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            setn,
    input  logic            fclk,
    input  logic [CMSB:0]   div,
    lsrx_frame_if.slave     bus,
    output logic [2:0]      cst,
    output logic [2:0]      nst,
    output logic            xst
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_DATA  = 3'b010,
        S_PAR   = 3'b011,
        S_STOP  = 3'b100
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_xst;

    // input capture / edge detection
    logic r_fclk_d, r_fclk_q;
    logic r_pop_d,  r_pop_q;
    logic r_clr_d,  r_clr_q;
    logic r_rx_s1,  r_rx_s2, r_rx_prev;

    logic w_tick, w_pop, w_clr, w_rx, w_fall, w_sample;

    // bit timing and shift register
    logic [CMSB:0] r_cnt;
    logic [CMSB:0] r_div;
    logic [CMSB:0] w_reload;
    logic [BMSB:0] r_bth;
    logic [DMSB:0] r_data;

    // host-visible status
    logic [DMSB:0] r_rdata;
    logic          r_full;
    logic          r_ferr;
    logic          r_ovr;

    logic w_accept, w_ferr_set, w_ovr_set;
    logic w_stop_ok, w_par_ok, w_room;

`ifdef LSRX_FRAME_PARITY_EN
    logic r_par;
    logic r_perr;
    logic w_perr_set;
`endif

    // ------------------------------------------------------------------
    // Synchronisers and toggle edge detectors
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fclk_d  <= 1'b0;
            r_fclk_q  <= 1'b0;
            r_pop_d   <= 1'b0;
            r_pop_q   <= 1'b0;
            r_clr_d   <= 1'b0;
            r_clr_q   <= 1'b0;
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else if (setn) begin
            r_fclk_d  <= fclk;
            r_fclk_q  <= r_fclk_d;
            r_pop_d   <= bus.pop;
            r_pop_q   <= r_pop_d;
            r_clr_d   <= bus.clear;
            r_clr_q   <= r_clr_d;
            r_rx_s1   <= bus.rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_tick   = r_fclk_d ^ r_fclk_q;
    assign w_pop    = r_pop_d ^ r_pop_q;
    assign w_clr    = r_clr_d ^ r_clr_q;
    assign w_rx     = r_rx_s2;
    assign w_fall   = r_rx_prev & ~r_rx_s2;
    assign w_sample = w_tick & (r_cnt == '0);

    // Full bit period minus 1 = 2*div+1; the shift happens at counter width,
    // so the top bit of div drops out exactly as a CMSB+2-bit truncation.
    assign w_reload = (r_div << 1) | {{CMSB{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_xst   <= 1'b0;
        end else if (setn) begin
            r_state <= w_next;
            r_xst   <= (w_next != r_state);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and frame verdict
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_ferr_set = 1'b0;
        w_ovr_set  = 1'b0;
        w_stop_ok  = w_rx;
        w_room     = ~r_full | w_pop;
`ifdef LSRX_FRAME_PARITY_EN
        w_perr_set = 1'b0;
        w_par_ok   = ~(^{r_data, r_par});
`else
        w_par_ok   = 1'b1;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_fall) w_next = S_START;
            end
            S_START: begin
                // a high line at mid start bit is a glitch, not a frame
                if (w_sample) w_next = w_rx ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_sample && (r_bth == '0)) begin
`ifdef LSRX_FRAME_PARITY_EN
                    w_next = S_PAR;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef LSRX_FRAME_PARITY_EN
            S_PAR: begin
                if (w_sample) w_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_sample) begin
                    w_next     = S_IDLE;
                    w_accept   = w_stop_ok & w_par_ok & w_room;
                    w_ferr_set = ~w_stop_ok;
                    w_ovr_set  = w_stop_ok & w_par_ok & ~w_room;
`ifdef LSRX_FRAME_PARITY_EN
                    w_perr_set = ~w_par_ok;
`endif
                end
            end
            default: w_next = S_IDLE;
        endcase

        if (w_clr) w_next = S_IDLE;

        cst = r_state;
        nst = w_next;
    end

    // ------------------------------------------------------------------
    // Bit timing counter, bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_div  <= '0;
            r_bth  <= '0;
            r_data <= '0;
`ifdef LSRX_FRAME_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else if (setn) begin
            if (w_tick && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_cnt <= div;
                        r_div <= div;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        r_cnt <= w_reload;
                        r_bth <= (BMSB+1)'(DMSB);
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_data <= {w_rx, r_data[DMSB:1]};
                        r_cnt  <= w_reload;
                        r_bth  <= r_bth - 1'b1;
                    end
                end
`ifdef LSRX_FRAME_PARITY_EN
                S_PAR: begin
                    if (w_sample) begin
                        r_par <= w_rx;
                        r_cnt <= w_reload;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Host status: clear beats accept, accept beats pop
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdata <= '0;
            r_full  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (setn) begin
            if (w_clr) begin
                r_full <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_rdata <= r_data;
                    r_full  <= 1'b1;
                end else if (w_pop) begin
                    r_full  <= 1'b0;
                end
                if (w_ferr_set) r_ferr <= 1'b1;
                if (w_ovr_set)  r_ovr  <= 1'b1;
            end
        end
    end

`ifdef LSRX_FRAME_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perr <= 1'b0;
        end else if (setn) begin
            if (w_clr)           r_perr <= 1'b0;
            else if (w_perr_set) r_perr <= 1'b1;
        end
    end
    assign bus.perr = r_perr;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.rdata = r_rdata;
    assign bus.full  = r_full;
    assign bus.ferr  = r_ferr;
    assign bus.ovr   = r_ovr;
    assign xst       = r_xst;

endmodule

// File: tb/tb_lsrx_frame.sv
// tb_lsrx_frame
//   Directed bench for lsrx_frame with DMSB=9, div=1 and fclk toggling once
//   per clk, so one bit lasts 4 clk. Frames are driven bit by bit and the
//   expected words and flags are written out by hand.
module tb_lsrx_frame;
    localparam int BMSB = 3;
    localparam int DMSB = 9;
    localparam int CMSB = 12;
`ifdef LSRX_FRAME_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic            setn = 1'b1;
    logic            fclk = 1'b0;
    logic [CMSB:0]   div  = 13'd1;
    logic [2:0]      cst;
    logic [2:0]      nst;
    logic            xst;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    lsrx_frame_if #(.DMSB(DMSB)) ifc ();

    lsrx_frame #(
        .BMSB(BMSB),
        .DMSB(DMSB),
        .CMSB(CMSB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .setn (setn),
        .fclk (fclk),
        .div  (div),
        .bus  (ifc.slave),
        .cst  (cst),
        .nst  (nst),
        .xst  (xst)
    );

    initial forever #5 clk = ~clk;

    // one fclk edge between every pair of clk rising edges
    initial begin
        #2;
        forever #10 fclk = ~fclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; returns 1 time unit after the last edge of the stop
    // bit, so the accept edge is exactly one step later. pop_late toggles
    // pop so its strobe lands on the stop-bit sample cycle.
    task automatic send_frame(input logic [9:0] w, input logic stopb,
                              input logic par_flip, input logic pop_late);
        ifc.rx = 1'b0;
        step(4);
        for (int i = 0; i <= DMSB; i++) begin
            ifc.rx = w[i];
            step(4);
        end
        if (PAR_EN) begin
            ifc.rx = (^w) ^ par_flip;
            step(4);
        end
        ifc.rx = stopb;
        step(3);
        if (pop_late) ifc.pop = ~ifc.pop;
        step(1);
        ifc.rx = 1'b1;
    endtask

    initial begin
        ifc.rx    = 1'b1;
        ifc.pop   = 1'b0;
        ifc.clear = 1'b0;

        // reset state
        step(3);
        chk("rst_rdata", $unsigned(ifc.rdata), 32'h0);
        chk("rst_full",  ifc.full, 1'b0);
        chk("rst_ferr",  ifc.ferr, 1'b0);
        chk("rst_perr",  ifc.perr, 1'b0);
        chk("rst_ovr",   ifc.ovr,  1'b0);
        chk("rst_cst",   cst, 3'b000);
        chk("rst_xst",   xst, 1'b0);
        rstn = 1'b1;
        step(4);

        // clean frame, then pop
        send_frame(10'h1A5, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("f1_rdata", $unsigned(ifc.rdata), 32'h1A5);
        chk("f1_full",  ifc.full, 1'b1);
        chk("f1_ferr",  ifc.ferr, 1'b0);
        chk("f1_perr",  ifc.perr, 1'b0);
        chk("f1_ovr",   ifc.ovr,  1'b0);
        chk("f1_cst",   cst, 3'b000);
        ifc.pop = ~ifc.pop;
        step(1);
        chk("pop_full_1cyc", ifc.full, 1'b1);
        step(1);
        chk("pop_full_2cyc", ifc.full, 1'b0);
        chk("pop_rdata",     $unsigned(ifc.rdata), 32'h1A5);

        // quarter-bit low glitch: start, then false start back to idle
        step(4);
        ifc.rx = 1'b0;
        step(1);
        ifc.rx = 1'b1;
        step(2);
        chk("gl_cst_start", cst, 3'b001);
        chk("gl_xst_hi",    xst, 1'b1);
        chk("gl_nst_hold",  nst, 3'b001);
        step(1);
        chk("gl_xst_lo",    xst, 1'b0);
        chk("gl_nst_idle",  nst, 3'b000);
        step(1);
        chk("gl_cst_idle",  cst, 3'b000);
        step(8);
        chk("gl_full", ifc.full, 1'b0);
        chk("gl_ferr", ifc.ferr, 1'b0);
        chk("gl_ovr",  ifc.ovr,  1'b0);

        // framing error, then clear
        send_frame(10'h155, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("fe_ferr",  ifc.ferr, 1'b1);
        chk("fe_full",  ifc.full, 1'b0);
        chk("fe_rdata", $unsigned(ifc.rdata), 32'h1A5);
        ifc.clear = ~ifc.clear;
        step(2);
        chk("fe_clr_ferr", ifc.ferr, 1'b0);
        step(4);

        // overrun: second word arrives with no pop
        send_frame(10'h001, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("ov_a_full",  ifc.full, 1'b1);
        chk("ov_a_rdata", $unsigned(ifc.rdata), 32'h001);
        step(4);
        send_frame(10'h3FF, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("ov_b_rdata", $unsigned(ifc.rdata), 32'h001);
        chk("ov_b_ovr",   ifc.ovr,  1'b1);
        chk("ov_b_full",  ifc.full, 1'b1);
        ifc.clear = ~ifc.clear;
        step(2);
        chk("ov_clr_ovr",   ifc.ovr,  1'b0);
        chk("ov_clr_full",  ifc.full, 1'b0);
        chk("ov_clr_rdata", $unsigned(ifc.rdata), 32'h001);
        step(4);

        // pop coinciding with accept: consumed-then-refilled
        send_frame(10'h001, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("pr_a_full", ifc.full, 1'b1);
        step(4);
        send_frame(10'h3FF, 1'b1, 1'b0, 1'b1);
        step(1);
        chk("pr_b_rdata", $unsigned(ifc.rdata), 32'h3FF);
        chk("pr_b_full",  ifc.full, 1'b1);
        chk("pr_b_ovr",   ifc.ovr,  1'b0);
        ifc.pop = ~ifc.pop;
        step(2);
        chk("pr_pop_full", ifc.full, 1'b0);

`ifdef LSRX_FRAME_PARITY_EN
        // 0x003 has even data parity, so a parity bit of 1 is wrong
        step(4);
        send_frame(10'h003, 1'b1, 1'b1, 1'b0);
        step(1);
        chk("pe_perr",  ifc.perr, 1'b1);
        chk("pe_full",  ifc.full, 1'b0);
        chk("pe_rdata", $unsigned(ifc.rdata), 32'h3FF);
        ifc.clear = ~ifc.clear;
        step(2);
        chk("pe_clr_perr", ifc.perr, 1'b0);
`endif

        // reset in the middle of the data bits
        step(4);
        ifc.rx = 1'b0;
        step(16);
        rstn   = 1'b0;
        ifc.rx = 1'b1;
        step(2);
        chk("mr_rdata", $unsigned(ifc.rdata), 32'h0);
        chk("mr_full",  ifc.full, 1'b0);
        chk("mr_ferr",  ifc.ferr, 1'b0);
        chk("mr_ovr",   ifc.ovr,  1'b0);
        chk("mr_cst",   cst, 3'b000);
        chk("mr_xst",   xst, 1'b0);
        rstn = 1'b1;
        step(4);
        send_frame(10'h2AA, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("mr_f_rdata", $unsigned(ifc.rdata), 32'h2AA);
        chk("mr_f_full",  ifc.full, 1'b1);
        chk("mr_f_ferr",  ifc.ferr, 1'b0);
        chk("mr_f_ovr",   ifc.ovr,  1'b0);
        step(20);
        chk("mr_end_cst", cst, 3'b000);
        chk("mr_end_ovr", ifc.ovr, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
